// File: rtl/vga_pwm_decode.sv
// Rebuilds 8-bit-per-channel RGB from 6-bit line-phase PWM dithered video by
// summing each pixel column over the four lines of one phase cycle.
module vga_pwm_decode #(
  parameter int MAX_WIDTH = 1024,
  parameter int AW        = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce_pix,
  input  logic        de,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        csync_en,
  input  logic        csync,
  input  logic [17:0] din,
  output logic [23:0] dout,
  output logic        dout_valid,
  output logic [1:0]  phase,
  output logic        locked,
  output logic        overrun
);

  // x needs one extra bit so it can sit at MAX_WIDTH once a line runs long.
  localparam logic [AW:0] X_LIMIT = (AW+1)'(MAX_WIDTH);

  // Valid/ready note: this is a pure streaming path with no backpressure.
  // A pixel is accepted on any clk with ce_pix & de & (x < MAX_WIDTH);
  // dout_valid is a one-clk strobe exactly two clks after that acceptance.

  logic        ls_q, ls_q2;
  logic        vs_q, vs_q2;
  logic        ls_fall, vs_fall;

  logic [AW:0] x;
  logic        pix_take;
  logic        in_range;
  logic        acc_en;

  logic          s1_valid;
  logic [AW-1:0] s1_addr;
  logic [17:0]   s1_din;
  logic [1:0]    s1_phase;
  logic          s1_locked;

  logic [23:0] rd_q;
  logic [23:0] sum;
  logic [7:0]  base_r, base_g, base_b;

  logic        s2_valid;
  logic        s2_emit;
  logic [23:0] s2_sum;

  logic [23:0] line_mem [0:MAX_WIDTH-1];

  // Sync inputs are sampled every clk, independent of the pixel enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ls_q  <= 1'b1;
      ls_q2 <= 1'b1;
      vs_q  <= 1'b1;
      vs_q2 <= 1'b1;
    end else begin
      ls_q  <= csync_en ? csync : hsync;
      ls_q2 <= ls_q;
      vs_q  <= vsync;
      vs_q2 <= vs_q;
    end
  end

  assign ls_fall = ls_q2 & ~ls_q;
  assign vs_fall = vs_q2 & ~vs_q;

  // Frame alignment takes priority over a coincident line edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase  <= 2'd0;
      locked <= 1'b0;
    end else if (vs_fall) begin
      phase  <= 2'd0;
      locked <= 1'b1;
    end else if (ls_fall) begin
      phase  <= phase + 2'd1;
    end
  end

  assign pix_take = ce_pix & de;
  assign in_range = (x < X_LIMIT);
  assign acc_en   = pix_take & in_range;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x       <= '0;
      overrun <= 1'b0;
    end else begin
      if (ls_fall) begin
        x <= '0;
      end else if (acc_en) begin
        x <= x + 1'b1;
      end
      if (pix_take && !in_range) begin
        overrun <= 1'b1;
      end
    end
  end

  // Stage 1: din, phase and lock are captured with the read so a later
  // line edge cannot change how an in-flight pixel is accumulated.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_addr   <= '0;
      s1_din    <= '0;
      s1_phase  <= 2'd0;
      s1_locked <= 1'b0;
    end else begin
      s1_valid <= acc_en;
      if (acc_en) begin
        s1_addr   <= x[AW-1:0];
        s1_din    <= din;
        s1_phase  <= phase;
        s1_locked <= locked;
      end
    end
  end

  // Line buffer: sync read in stage 1, write-back of the new sum in stage 2.
  always_ff @(posedge clk) begin
    if (acc_en) begin
      rd_q <= line_mem[x[AW-1:0]];
    end
    if (s1_valid) begin
      line_mem[s1_addr] <= sum;
    end
  end

  // Phase 0 starts a fresh column sum; stale buffer contents are ignored.
  always_comb begin
    base_r = 8'd0;
    base_g = 8'd0;
    base_b = 8'd0;
    if (s1_phase != 2'd0) begin
      base_r = rd_q[23:16];
      base_g = rd_q[15:8];
      base_b = rd_q[7:0];
    end
    sum[23:16] = base_r + {2'b00, s1_din[17:12]};
    sum[15:8]  = base_g + {2'b00, s1_din[11:6]};
    sum[7:0]   = base_b + {2'b00, s1_din[5:0]};
  end

  // Stage 2: register the completed sum and whether it finishes a cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_emit  <= 1'b0;
      s2_sum   <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_emit  <= (s1_phase == 2'd3) & s1_locked;
      if (s1_valid) begin
        s2_sum <= sum;
      end
    end
  end

  // Stage 3: dout holds between strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= s2_valid & s2_emit;
      if (s2_valid && s2_emit) begin
        dout <= s2_sum;
      end
    end
  end

endmodule

// File: tb/tb_vga_pwm_decode.sv
// Directed bench for vga_pwm_decode: encoder-model stimulus, expected RGB
// queued at issue time, checked by a monitor on each dout_valid strobe.
module tb_vga_pwm_decode;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ce_pix, de, hsync, vsync, csync_en, csync;
  logic [17:0] din;
  logic [23:0] dout;
  logic        dout_valid;
  logic [1:0]  phase;
  logic        locked, overrun;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [23:0] exp_q[$];
  int          exp_cyc_q[$];
  logic [23:0] hold_ref = 24'h0;
  logic [23:0] mon_exp;
  int          mon_cyc;

  // Hand-computed colour table and the RGB expected after four lines.
  logic [23:0] col_tbl [5] = '{24'hC70180, 24'hFFFFFF, 24'h7F3E05, 24'hFD0203, 24'h000000};
  logic [23:0] exp_tbl [5] = '{24'hC70180, 24'hFCFCFC, 24'h7F3E05, 24'hFC0203, 24'h000000};

  vga_pwm_decode #(.MAX_WIDTH(1024), .AW(10)) dut (
    .clk(clk), .reset(reset), .ce_pix(ce_pix), .de(de), .hsync(hsync),
    .vsync(vsync), .csync_en(csync_en), .csync(csync), .din(din),
    .dout(dout), .dout_valid(dout_valid), .phase(phase), .locked(locked),
    .overrun(overrun)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] enc_ch(input logic [7:0] v, input int ph);
    if (v[7:2] == 6'd63) return 6'd63;
    return v[7:2] + ((ph < int'(v[1:0])) ? 6'd1 : 6'd0);
  endfunction

  function automatic logic [17:0] enc(input logic [23:0] c, input int ph);
    return {enc_ch(c[23:16], ph), enc_ch(c[15:8], ph), enc_ch(c[7:0], ph)};
  endfunction

  function automatic logic [23:0] color_of(input int pat, input int i);
    if (pat == 0) return 24'h000080;
    return col_tbl[i % 5];
  endfunction

  function automatic logic [23:0] expect_of(input int pat, input int i);
    if (pat == 0) return 24'h000080;
    return exp_tbl[i % 5];
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (reset) begin
      hold_ref = 24'h0;
    end else if (dout_valid) begin
      if (exp_q.size() == 0) begin
        check("valid_without_expect", 32'(dout_valid), 32'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_cyc = exp_cyc_q.pop_front();
        check("dout", 32'(dout), 32'(mon_exp));
        check("latency", cyc, mon_cyc);
        hold_ref = mon_exp;
      end
    end else begin
      check("dout_hold", 32'(dout), 32'(hold_ref));
    end
  end

  // ---------------- driver ----------------
  // One video line: sync pulse, short blank, npix active pixels, blank tail.
  // rst_at >= 0 asserts reset just before that pixel and abandons the line.
  task automatic run_line(input int ph, input bit first, input int npix, input int ce_div,
                          input bit cs, input int pat, input bit push_exp, input int rst_at);
    if (first) vsync = 1'b0;
    if (cs) csync = 1'b0;
    else    hsync = 1'b0;
    tick(); tick(); tick();
    hsync = 1'b1; csync = 1'b1; vsync = 1'b1;
    tick(); tick();
    check("phase", 32'(phase), 32'(ph));
    if (first) check("locked_after_vsync", 32'(locked), 32'd1);
    ce_pix = 1'b1; de = 1'b0;
    tick(); tick();
    for (int i = 0; i < npix; i++) begin
      if (i == rst_at) begin
        reset = 1'b1;
        #1;
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_valid", 32'(dout_valid), 32'd0);
        check("rst_phase", 32'(phase), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        de = 1'b0;
        return;
      end
      din = enc(color_of(pat, i), ph);
      ce_pix = 1'b1; de = 1'b1;
      if (push_exp && ph == 3 && i < 1024) begin
        exp_q.push_back(expect_of(pat, i));
        exp_cyc_q.push_back(cyc + 3);
      end
      tick();
      if (npix > 1024 && ph == 0 && i == 1023) check("overrun_pre", 32'(overrun), 32'd0);
      if (npix > 1024 && i == 1024) check("overrun_set", 32'(overrun), 32'd1);
      for (int k = 1; k < ce_div; k++) begin
        ce_pix = 1'b0;
        din = 18'($urandom_range(0, 262143));
        tick();
      end
    end
    de = 1'b0; ce_pix = 1'b1; din = '0;
    tick(); tick(); tick(); tick();
  endtask

  task automatic run_frame(input int npix, input int ce_div, input bit cs, input int pat);
    csync_en = cs;
    for (int l = 0; l < 4; l++) run_line(l, (l == 0), npix, ce_div, cs, pat, 1'b1, -1);
    for (int k = 0; k < 40 && exp_q.size() > 0; k++) tick();
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    ce_pix = 1'b0; de = 1'b0; hsync = 1'b1; vsync = 1'b1;
    csync = 1'b1; csync_en = 1'b0; din = '0;
    tick(); tick(); tick();
    check("reset_dout", 32'(dout), 32'd0);
    check("reset_valid", 32'(dout_valid), 32'd0);
    check("reset_phase", 32'(phase), 32'd0);
    check("reset_locked", 32'(locked), 32'd0);
    check("reset_overrun", 32'(overrun), 32'd0);
    reset = 1'b0;
    tick();

    // Flat blue 0x80, then mixed colours incl. saturation cases.
    run_frame(8, 1, 1'b0, 0);
    run_frame(10, 1, 1'b0, 1);

    // Sparse pixel enable with composite sync as the line source.
    run_frame(6, 3, 1'b1, 0);
    run_frame(10, 3, 1'b1, 1);

    // Over-long lines: only the first 1024 columns are accumulated.
    check("overrun_before", 32'(overrun), 32'd0);
    run_frame(1030, 1, 1'b0, 1);
    check("overrun_sticky", 32'(overrun), 32'd1);

    // Reset in the middle of a phase-2 line.
    csync_en = 1'b0;
    run_line(0, 1'b1, 8, 1, 1'b0, 0, 1'b0, -1);
    run_line(1, 1'b0, 8, 1, 1'b0, 0, 1'b0, -1);
    run_line(2, 1'b0, 8, 1, 1'b0, 0, 1'b0, 3);
    tick(); tick();
    reset = 1'b0;
    tick();
    for (int l = 0; l < 4; l++) run_line((l + 1) % 4, 1'b0, 8, 1, 1'b0, 0, 1'b0, -1);
    check("unlocked_no_vsync", 32'(locked), 32'd0);
    run_frame(8, 1, 1'b0, 0);

    tick(); tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
